// File: rtl/alu_wb_buffer_if.sv
// Handshake bundle between the ALU result producer, the writeback buffer and the register file.
// The slave modport is the buffer side; master is the producer/consumer side.
interface alu_wb_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_result;
    logic            in_zero;
    logic [3:0]      in_op;
    logic [4:0]      in_rd;

    logic            wb_valid;
    logic            wb_ready;
    logic [31:0]     wb_data;
    logic [4:0]      wb_rd;
    logic            wb_we;
    logic            wb_zero;
    logic            wb_unordered;
    logic [CntW-1:0] count;

    modport slave (
        input  in_valid, in_result, in_zero, in_op, in_rd, wb_ready,
        output in_ready, wb_valid, wb_data, wb_rd, wb_we, wb_zero, wb_unordered, count
    );

    modport master (
        output in_valid, in_result, in_zero, in_op, in_rd, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_rd, wb_we, wb_zero, wb_unordered, count
    );
endinterface

// File: rtl/alu_wb_buffer.sv
// Circular FIFO buffering ALU results ahead of register-file writeback.
// Define ALU_WB_BYPASS_EN to forward an incoming result straight to writeback when empty.
module alu_wb_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_wb_buffer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [3:0]  OpFcmp = 4'b1000;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [3:0]  op;
        logic [4:0]  rd;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    entry_t in_entry;
    entry_t head;
    logic   empty;
    logic   in_ready;
    logic   bypass;
    logic   push;
    logic   pop;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != CntW'(DEPTH));

`ifdef ALU_WB_BYPASS_EN
    // Empty buffer with a consumer ready: hand the result over without storing it.
    assign bypass = empty && bus.in_valid && bus.wb_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = bus.in_valid && in_ready && !bypass;
    assign pop  = !empty && bus.wb_ready;

    always_comb begin
        in_entry        = '0;
        in_entry.result = bus.in_result;
        in_entry.zero   = bus.in_zero;
        in_entry.op     = bus.in_op;
        in_entry.rd     = bus.in_rd;
    end

    always_comb begin
        head = mem_q[rd_ptr_q];
        if (bypass) begin
            head = in_entry;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared too so the head fields read as zero straight after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.wb_valid     = !empty || bypass;
    assign bus.wb_data      = head.result;
    assign bus.wb_rd        = head.rd;
    assign bus.wb_zero      = head.zero;
    assign bus.wb_we        = bus.wb_valid && (head.rd != 5'd0);
    assign bus.wb_unordered = (head.op == OpFcmp) && (head.result[1:0] == 2'b11);
    assign bus.count        = count_q;
endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed self-checking bench for alu_wb_buffer with a queue-based scoreboard.
// Honours ALU_WB_BYPASS_EN when the design is built with it.
module tb_alu_wb_buffer;
    localparam int unsigned Depth = 4;
`ifdef ALU_WB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [3:0]  op;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    alu_wb_buffer_if #(.DEPTH(Depth)) u ();

    alu_wb_buffer #(.DEPTH(Depth)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic z,
                         input logic [3:0] op, input logic [4:0] rd);
        u.in_valid  = v;
        u.in_result = res;
        u.in_zero   = z;
        u.in_op     = op;
        u.in_rd     = rd;
    endtask

    // Sample mid-cycle, update the scoreboard for the coming edge, then step past the edge.
    task automatic tick();
        exp_t e;
        int   n;
        logic exp_v;
        @(negedge clk);
        n     = q.size();
        exp_v = (n > 0) || (Byp && n == 0 && u.in_valid && u.wb_ready);
        chk("count", u.count, n);
        chk("in_ready", u.in_ready, n < Depth);
        chk("wb_valid", u.wb_valid, exp_v);
        if (u.in_valid && n < Depth) begin
            e.res = u.in_result;
            e.z   = u.in_zero;
            e.op  = u.in_op;
            e.rd  = u.in_rd;
            q.push_back(e);
        end
        if (exp_v && q.size() > 0) begin
            e = q[0];
            chk("wb_data", u.wb_data, e.res);
            chk("wb_rd", u.wb_rd, e.rd);
            chk("wb_zero", u.wb_zero, e.z);
            chk("wb_we", u.wb_we, e.rd != 5'd0);
            chk("wb_unordered", u.wb_unordered, (e.op == 4'b1000) && (e.res[1:0] == 2'b11));
            if (u.wb_ready) begin
                void'(q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    // A push is presented during reset to confirm it is dropped.
    task automatic reset_tick();
        rst_n = 1'b0;
        drive(1'b1, 32'hdead_beef, 1'b1, 4'h8, 5'd7);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        chk("rst_count", u.count, 0);
        chk("rst_in_ready", u.in_ready, 1);
        chk("rst_wb_valid", u.wb_valid, 0);
        chk("rst_wb_we", u.wb_we, 0);
        chk("rst_wb_unordered", u.wb_unordered, 0);
        chk("rst_wb_data", u.wb_data, 0);
        chk("rst_wb_rd", u.wb_rd, 0);
        chk("rst_wb_zero", u.wb_zero, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        u.wb_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        reset_tick();

        // Single entry.
        u.wb_ready = 1'b1;
        drive(1'b1, 32'h0000_0005, 1'b0, 4'h0, 5'd3);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        tick();
        tick();
        chk("single_drained", u.count, 0);

        // Fill with the consumer stalled; the fifth push must be refused.
        u.wb_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(i), 1'b0, 4'h1, 5'(i));
            tick();
        end
        chk("fill_count", u.count, 4);
        chk("fill_in_ready", u.in_ready, 0);

        // Pop at full with the fifth entry still held on the input.
        u.wb_ready = 1'b1;
        tick();
        u.wb_ready = 1'b0;
        chk("full_pop_count", u.count, 3);
        chk("full_pop_in_ready", u.in_ready, 1);
        tick();
        chk("held_accepted", u.count, 4);
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        u.wb_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("fill_drained", u.count, 0);

        // Streaming across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(100 + i), i[0], 4'(i), 5'(i + 1));
            tick();
            chk("stream_cnt_le1", u.count <= 1, 1);
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        tick();
        tick();

        // Flags: float-compare unordered, rd 0 suppresses write enable.
        u.wb_ready = 1'b0;
        drive(1'b1, 32'h0000_0003, 1'b1, 4'b1000, 5'd0);
        tick();
        chk("flag_unordered", u.wb_unordered, 1);
        chk("flag_we", u.wb_we, 0);
        chk("flag_zero", u.wb_zero, 1);
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        u.wb_ready = 1'b1;
        tick();
        drive(1'b1, 32'h0000_0002, 1'b0, 4'b1000, 5'd7);
        tick();
        drive(1'b1, 32'h0000_0003, 1'b1, 4'b0000, 5'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        tick();
        tick();

        // Reset with three entries queued; none may reappear.
        u.wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(200 + i), 1'b0, 4'h2, 5'(10 + i));
            tick();
        end
        chk("pre_reset_count", u.count, 3);
        reset_tick();
        u.wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        drive(1'b1, 32'd77, 1'b0, 4'h3, 5'd9);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 5'd0);
        tick();
        tick();
        chk("sb_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
